// File: rtl/input_selector_scheduler.sv
// Steps the selector block's selection word through a host-written table, holding each entry for its dwell.
// Define INPUT_SELECTOR_SCHED_SKIP_EN to skip zero-dwell entries instead of holding them for one cycle.
module input_selector_scheduler #(
    parameter int MAIN_INPUTS     = 16,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS         = 4,
    parameter int OUTPUTS_PER_BUS = 4,
    parameter int STEPS           = 8,
    parameter int DWELL_WIDTH     = 8,
    localparam int SEL_W = 1 + $clog2(MAIN_INPUTS) + $clog2(REGS_INPUTS),
    localparam int CFG_W = OUTPUTS * OUTPUTS_PER_BUS * SEL_W,
    localparam int IDX_W = $clog2(STEPS)
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   wCfgWrEn,
    input  logic [IDX_W-1:0]       wCfgAddr,
    input  logic [CFG_W-1:0]       wCfgSelec,
    input  logic [DWELL_WIDTH-1:0] wCfgDwell,
    input  logic [IDX_W:0]         wNumSteps,
    input  logic                   wLoop,
    input  logic                   wStart,
    input  logic                   wStop,
    output logic [CFG_W-1:0]       wSelec,
    output logic                   wBusy,
    output logic [IDX_W-1:0]       wStepIdx,
    output logic                   wRunning,
    output logic                   wDone
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W:0]       MAX_STEPS = (IDX_W+1)'(STEPS);
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

    logic [CFG_W-1:0]       tbl_selec [STEPS];
    logic [DWELL_WIDTH-1:0] tbl_dwell [STEPS];

    logic [1:0]             state, state_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [IDX_W:0]         n, n_d;
    logic                   loop_r, loop_d;
    logic [DWELL_WIDTH-1:0] cnt, cnt_d;
    logic [CFG_W-1:0]       selec_d;

    logic                   dwell_zero;
    logic                   last_step;
    logic [1:0]             adv_state;
    logic [IDX_W-1:0]       adv_idx;

    // Table has no reset; a LOAD in the same cycle as a write sees the old entry.
    always_ff @(posedge clk) begin
        if (wCfgWrEn) begin
            tbl_selec[wCfgAddr] <= wCfgSelec;
            tbl_dwell[wCfgAddr] <= wCfgDwell;
        end
    end

    assign dwell_zero = (tbl_dwell[idx] == '0);
    assign last_step  = ({1'b0, idx} == (n - 1'b1));

    // Where the schedule goes once the current step is finished.
    always_comb begin
        adv_state = S_LOAD;
        adv_idx   = idx + 1'b1;
        if (last_step) begin
            adv_idx   = '0;
            adv_state = loop_r ? S_LOAD : S_DONE;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        n_d     = n;
        loop_d  = loop_r;
        cnt_d   = cnt;
        selec_d = wSelec;
        case (state)
            S_IDLE: begin
                if (wStart && !wStop && (wNumSteps != '0)) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    n_d     = (wNumSteps > MAX_STEPS) ? MAX_STEPS : wNumSteps;
                    loop_d  = wLoop;
                end
            end
            S_LOAD: begin
`ifdef INPUT_SELECTOR_SCHED_SKIP_EN
                if (dwell_zero) begin
                    state_d = adv_state;
                    if (adv_state == S_LOAD) idx_d = adv_idx;
                end else begin
                    selec_d = tbl_selec[idx];
                    cnt_d   = tbl_dwell[idx];
                    state_d = S_HOLD;
                end
`else
                selec_d = tbl_selec[idx];
                cnt_d   = dwell_zero ? DWELL_ONE : tbl_dwell[idx];
                state_d = S_HOLD;
`endif
            end
            S_HOLD: begin
                if (cnt == DWELL_ONE) begin
                    state_d = adv_state;
                    if (adv_state == S_LOAD) idx_d = adv_idx;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything and freezes the selection where it is.
        if (wStop && (state != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = idx;
            selec_d = wSelec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state  <= S_IDLE;
            idx    <= '0;
            n      <= '0;
            loop_r <= 1'b0;
            cnt    <= '0;
            wSelec <= '0;
            wBusy  <= 1'b1;
            wDone  <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            n      <= n_d;
            loop_r <= loop_d;
            cnt    <= cnt_d;
            wSelec <= selec_d;
            wBusy  <= (state_d != S_HOLD);
            wDone  <= (state_d == S_DONE);
        end
    end

    assign wStepIdx = idx;
    assign wRunning = (state == S_LOAD) || (state == S_HOLD);

endmodule

// File: tb/tb_input_selector_scheduler.sv
// Directed bench for input_selector_scheduler: a per-cycle vector table for a one-shot run plus
// hand-written sequences for looping, abort, clamping, mid-run table writes and zero dwell.
module tb_input_selector_scheduler;

    localparam int CFG_W = 176;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             wCfgWrEn;
    logic [IDX_W-1:0] wCfgAddr;
    logic [CFG_W-1:0] wCfgSelec;
    logic [7:0]       wCfgDwell;
    logic [IDX_W:0]   wNumSteps;
    logic             wLoop, wStart, wStop;
    logic [CFG_W-1:0] wSelec;
    logic             wBusy;
    logic [IDX_W-1:0] wStepIdx;
    logic             wRunning, wDone;

    int checks   = 0;
    int failures = 0;

    input_selector_scheduler dut (
        .clk(clk), .reset_L(reset_L), .wCfgWrEn(wCfgWrEn), .wCfgAddr(wCfgAddr),
        .wCfgSelec(wCfgSelec), .wCfgDwell(wCfgDwell), .wNumSteps(wNumSteps), .wLoop(wLoop),
        .wStart(wStart), .wStop(wStop), .wSelec(wSelec), .wBusy(wBusy), .wStepIdx(wStepIdx),
        .wRunning(wRunning), .wDone(wDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             we;
        logic [IDX_W-1:0] addr;
        logic [CFG_W-1:0] sel_in;
        logic [7:0]       dwell_in;
        logic [IDX_W:0]   ns;
        logic             loop_in;
        logic             start;
        logic             stop;
        logic             exp_busy;
        logic             exp_run;
        logic             exp_done;
        logic [IDX_W-1:0] exp_idx;
        logic [CFG_W-1:0] exp_sel;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [CFG_W-1:0] pat(input logic [10:0] v);
        return {16{v}};
    endfunction

    function automatic vec_t mk(input logic we, input logic [IDX_W-1:0] addr,
                                input logic [CFG_W-1:0] sel_in, input logic [7:0] dwell_in,
                                input logic start, input logic exp_busy, input logic exp_run,
                                input logic exp_done, input logic [IDX_W-1:0] exp_idx,
                                input logic [CFG_W-1:0] exp_sel);
        vec_t v;
        v.we = we; v.addr = addr; v.sel_in = sel_in; v.dwell_in = dwell_in;
        v.ns = 4'd3; v.loop_in = 1'b0; v.start = start; v.stop = 1'b0;
        v.exp_busy = exp_busy; v.exp_run = exp_run; v.exp_done = exp_done;
        v.exp_idx = exp_idx; v.exp_sel = exp_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wCfgWrEn = 1'b0; wCfgAddr = '0; wCfgSelec = '0; wCfgDwell = '0;
        wNumSteps = '0; wLoop = 1'b0; wStart = 1'b0; wStop = 1'b0;
    endtask

    task automatic write_entry(input logic [IDX_W-1:0] a, input logic [CFG_W-1:0] s, input logic [7:0] d);
        wCfgWrEn = 1'b1; wCfgAddr = a; wCfgSelec = s; wCfgDwell = d;
        tick();
        wCfgWrEn = 1'b0;
    endtask

    task automatic start_run(input logic [IDX_W:0] ns, input logic lp);
        wNumSteps = ns; wLoop = lp; wStart = 1'b1;
        tick();
        wStart = 1'b0;
    endtask

    task automatic check_idle(input string name, input logic [CFG_W-1:0] sel);
        chk({name, "_busy"}, CFG_W'(wBusy), CFG_W'(1));
        chk({name, "_run"}, CFG_W'(wRunning), CFG_W'(0));
        chk({name, "_done"}, CFG_W'(wDone), CFG_W'(0));
        chk({name, "_sel"}, wSelec, sel);
    endtask

    // Steps until wDone, bounded; reports cycles taken, highest step index and whether B was held.
    task automatic wait_done(input logic [CFG_W-1:0] b_sel, output int cycles, output int max_idx,
                             output bit saw_b);
        cycles = 0; max_idx = 0; saw_b = 0;
        while (!wDone && cycles < 200) begin
            tick();
            cycles++;
            if (int'(wStepIdx) > max_idx) max_idx = int'(wStepIdx);
            if (wRunning && !wBusy && wSelec == b_sel) saw_b = 1;
        end
        chk("done_timeout", CFG_W'(wDone), CFG_W'(1));
    endtask

    logic [CFG_W-1:0] sa, sb, sc, sd, se;
    int cyc, mx;
    bit saw;

    initial begin
        sa = pat(11'h101); sb = pat(11'h202); sc = pat(11'h303);
        sd = pat(11'h404); se = pat(11'h505);

        // Table writes then a one-shot 3-step run, one row per clock.
        vecs[0]  = mk(1, 0, sa, 3, 0, 1, 0, 0, 0, '0);
        vecs[1]  = mk(1, 1, sb, 1, 0, 1, 0, 0, 0, '0);
        vecs[2]  = mk(1, 2, sc, 2, 0, 1, 0, 0, 0, '0);
        vecs[3]  = mk(0, 0, '0, 0, 1, 1, 1, 0, 0, '0);
        vecs[4]  = mk(0, 0, '0, 0, 0, 0, 1, 0, 0, sa);
        vecs[5]  = mk(0, 0, '0, 0, 0, 0, 1, 0, 0, sa);
        vecs[6]  = mk(0, 0, '0, 0, 0, 0, 1, 0, 0, sa);
        vecs[7]  = mk(0, 0, '0, 0, 0, 1, 1, 0, 1, sa);
        vecs[8]  = mk(0, 0, '0, 0, 0, 0, 1, 0, 1, sb);
        vecs[9]  = mk(0, 0, '0, 0, 0, 1, 1, 0, 2, sb);
        vecs[10] = mk(0, 0, '0, 0, 0, 0, 1, 0, 2, sc);
        vecs[11] = mk(0, 0, '0, 0, 0, 0, 1, 0, 2, sc);
        vecs[12] = mk(0, 0, '0, 0, 0, 1, 0, 1, 2, sc);
        vecs[13] = mk(0, 0, '0, 0, 0, 1, 0, 0, 2, sc);

        // Clock/reset
        idle_inputs();
        reset_L = 1'b0;
        tick(); tick();
        check_idle("reset", '0);
        chk("reset_idx", CFG_W'(wStepIdx), '0);
        reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("idle5", '0);
        end

        for (int i = 0; i < 14; i++) begin
            wCfgWrEn = vecs[i].we; wCfgAddr = vecs[i].addr; wCfgSelec = vecs[i].sel_in;
            wCfgDwell = vecs[i].dwell_in; wNumSteps = vecs[i].ns; wLoop = vecs[i].loop_in;
            wStart = vecs[i].start; wStop = vecs[i].stop;
            tick();
            chk($sformatf("vec%0d_busy", i), CFG_W'(wBusy), CFG_W'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_run", i), CFG_W'(wRunning), CFG_W'(vecs[i].exp_run));
            chk($sformatf("vec%0d_done", i), CFG_W'(wDone), CFG_W'(vecs[i].exp_done));
            chk($sformatf("vec%0d_idx", i), CFG_W'(wStepIdx), CFG_W'(vecs[i].exp_idx));
            chk($sformatf("vec%0d_sel", i), wSelec, vecs[i].exp_sel);
        end
        idle_inputs();

        // Loop mode: wraps back to A, then abort during B's hold.
        start_run(4'd3, 1'b1);
        repeat (9) tick();
        chk("loop_wrap_idx", CFG_W'(wStepIdx), '0);
        chk("loop_wrap_busy", CFG_W'(wBusy), CFG_W'(1));
        chk("loop_wrap_run", CFG_W'(wRunning), CFG_W'(1));
        tick();
        chk("loop_a_sel", wSelec, sa);
        chk("loop_a_busy", CFG_W'(wBusy), CFG_W'(0));
        repeat (4) tick();
        chk("loop_b_sel", wSelec, sb);
        chk("loop_b_busy", CFG_W'(wBusy), CFG_W'(0));
        wStop = 1'b1;
        tick();
        wStop = 1'b0;
        check_idle("stop", sb);
        tick();
        check_idle("stop_after", sb);

        // Length above table depth clamps to all 8 steps.
        for (int i = 3; i < 8; i++) write_entry(IDX_W'(i), pat(11'(16 + i)), 8'd1);
        start_run(4'd12, 1'b0);
        wait_done(sb, cyc, mx, saw);
        chk("clamp_cycles", CFG_W'(cyc), CFG_W'(19));
        chk("clamp_max_idx", CFG_W'(mx), CFG_W'(7));
        chk("clamp_final_sel", wSelec, pat(11'd23));
        tick();
        check_idle("clamp_end", pat(11'd23));

        // Zero length and start+stop together are both ignored.
        start_run(4'd0, 1'b0);
        check_idle("ns0", pat(11'd23));
        tick();
        check_idle("ns0_b", pat(11'd23));
        wStop = 1'b1;
        start_run(4'd3, 1'b0);
        wStop = 1'b0;
        check_idle("start_stop", pat(11'd23));

        // Mid-run writes: D lands before the LOAD, E on the LOAD cycle itself.
        start_run(4'd3, 1'b1);
        repeat (5) tick();
        chk("wr_hold_b", wSelec, sb);
        wCfgWrEn = 1'b1; wCfgAddr = 3'd2; wCfgSelec = sd; wCfgDwell = 8'd2;
        tick();
        chk("wr_load_busy", CFG_W'(wBusy), CFG_W'(1));
        chk("wr_load_idx", CFG_W'(wStepIdx), CFG_W'(2));
        wCfgSelec = se;
        tick();
        wCfgWrEn = 1'b0;
        chk("wr_uses_d", wSelec, sd);
        repeat (8) tick();
        chk("wr_load2_idx", CFG_W'(wStepIdx), CFG_W'(2));
        chk("wr_load2_busy", CFG_W'(wBusy), CFG_W'(1));
        tick();
        chk("wr_uses_e", wSelec, se);
        wStop = 1'b1;
        tick();
        wStop = 1'b0;
        check_idle("wr_stop", se);

        // Zero-dwell middle entry.
        write_entry(3'd1, sb, 8'd0);
        write_entry(3'd2, sc, 8'd2);
        start_run(4'd3, 1'b0);
        wait_done(sb, cyc, mx, saw);
`ifdef INPUT_SELECTOR_SCHED_SKIP_EN
        chk("zero_cycles", CFG_W'(cyc), CFG_W'(8));
        chk("zero_saw_b", CFG_W'(saw), CFG_W'(0));
`else
        chk("zero_cycles", CFG_W'(cyc), CFG_W'(9));
        chk("zero_saw_b", CFG_W'(saw), CFG_W'(1));
`endif
        chk("zero_final_sel", wSelec, sc);

        // Reset in the middle of a run.
        tick();
        start_run(4'd3, 1'b1);
        repeat (3) tick();
        reset_L = 1'b0;
        tick();
        check_idle("midreset", '0);
        chk("midreset_idx", CFG_W'(wStepIdx), '0);
        reset_L = 1'b1;
        tick();
        check_idle("midreset_after", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
